// File: rtl/sio_fifo_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | sio_fifo_ctrl: polls a byte-wide serial port and moves bytes between it  |
// | and host-side TX/RX FIFOs. Optional byte counters: SIO_CTRL_CNT_EN.      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module sio_fifo_ctrl #(
  parameter int DEPTH_LOG2 = 3,
  parameter int POLL_GAP   = 4
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        en,
  input  logic        tx_wr,
  input  logic [7:0]  tx_data,
  output logic        tx_full,
  output logic        tx_drop,
  input  logic        rx_rd,
  output logic [7:0]  rx_data,
  output logic        rx_empty,
  output logic        sio_ce,
  output logic        sio_rd,
  output logic        sio_wr,
  output logic        sio_cd,
  output logic [7:0]  sio_wdata,
  input  logic [7:0]  sio_rdata
`ifdef SIO_CTRL_CNT_EN
  ,
  output logic [15:0] tx_bytes,
  output logic [15:0] rx_bytes
`endif
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int PW    = DEPTH_LOG2 + 1;
  // IDLE always lasts at least one cycle, so a gap of 0 or 1 behaves the same.
  localparam logic [15:0] GAP_LAST = (POLL_GAP > 1) ? 16'(POLL_GAP - 1) : 16'd0;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    POLL  = 3'd1,
    PCAP  = 3'd2,
    RXRD  = 3'd3,
    RXCAP = 3'd4,
    TXWR  = 3'd5
  } state_t;

  state_t      state, state_nxt;
  logic [15:0] gap_cnt, gap_nxt;
  logic        last_tx, last_tx_nxt;

  // ---------------- TX FIFO ----------------
  logic [7:0]    tx_mem [DEPTH];
  logic [PW-1:0] tx_wp, tx_rp;
  logic          tx_empty, tx_push, tx_pop;
  logic [7:0]    tx_head;

  assign tx_empty = (tx_wp == tx_rp);
  assign tx_full  = (tx_wp[PW-1] != tx_rp[PW-1]) && (tx_wp[PW-2:0] == tx_rp[PW-2:0]);
  assign tx_pop   = (state == TXWR) && !tx_empty;
  assign tx_push  = tx_wr && (!tx_full || tx_pop);
  assign tx_drop  = tx_wr && !tx_push;
  assign tx_head  = tx_mem[tx_rp[PW-2:0]];

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wp[PW-2:0]] <= tx_data;
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      tx_wp <= '0;
      tx_rp <= '0;
    end else begin
      if (tx_push) tx_wp <= tx_wp + 1'b1;
      if (tx_pop)  tx_rp <= tx_rp + 1'b1;
    end
  end

  // ---------------- RX FIFO ----------------
  logic [7:0]    rx_mem [DEPTH];
  logic [PW-1:0] rx_wp, rx_rp;
  logic          rx_full, rx_push, rx_pop;

  assign rx_empty = (rx_wp == rx_rp);
  assign rx_full  = (rx_wp[PW-1] != rx_rp[PW-1]) && (rx_wp[PW-2:0] == rx_rp[PW-2:0]);
  assign rx_pop   = rx_rd && !rx_empty;
  assign rx_push  = (state == RXCAP) && (!rx_full || rx_pop);
  assign rx_data  = rx_mem[rx_rp[PW-2:0]];

  always_ff @(posedge clk) begin
    if (rx_push) rx_mem[rx_wp[PW-2:0]] <= sio_rdata;
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      rx_wp <= '0;
      rx_rp <= '0;
    end else begin
      if (rx_push) rx_wp <= rx_wp + 1'b1;
      if (rx_pop)  rx_rp <= rx_rp + 1'b1;
    end
  end

  // ---------------- Control FSM ----------------
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state   <= IDLE;
      gap_cnt <= '0;
      last_tx <= 1'b1;
    end else begin
      state   <= state_nxt;
      gap_cnt <= gap_nxt;
      last_tx <= last_tx_nxt;
    end
  end

  always_comb begin
    logic rx_ok, tx_ok;
    state_nxt   = state;
    gap_nxt     = gap_cnt;
    last_tx_nxt = last_tx;
    rx_ok       = sio_rdata[1] && !rx_full;
    tx_ok       = sio_rdata[0] && !tx_empty;
    unique case (state)
      IDLE: begin
        if (!en) begin
          gap_nxt = '0;
        end else if (gap_cnt == GAP_LAST) begin
          gap_nxt   = '0;
          state_nxt = POLL;
        end else begin
          gap_nxt = gap_cnt + 16'd1;
        end
      end
      POLL: state_nxt = PCAP;
      PCAP: begin
        // On a tie, serve whichever side did not go last.
        if (rx_ok && (!tx_ok || last_tx)) begin
          state_nxt   = RXRD;
          last_tx_nxt = 1'b0;
        end else if (tx_ok) begin
          state_nxt   = TXWR;
          last_tx_nxt = 1'b1;
        end else begin
          state_nxt = IDLE;
        end
      end
      RXRD:    state_nxt = RXCAP;
      RXCAP:   state_nxt = IDLE;
      TXWR:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Strobes are registered from the next state so they line up with the state.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      sio_ce    <= 1'b0;
      sio_rd    <= 1'b0;
      sio_wr    <= 1'b0;
      sio_cd    <= 1'b0;
      sio_wdata <= 8'h00;
    end else begin
      sio_ce    <= (state_nxt == POLL) || (state_nxt == RXRD) || (state_nxt == TXWR);
      sio_rd    <= (state_nxt == POLL) || (state_nxt == RXRD);
      sio_wr    <= (state_nxt == TXWR);
      sio_cd    <= (state_nxt == POLL);
      sio_wdata <= (state_nxt == TXWR) ? tx_head : 8'h00;
    end
  end

`ifdef SIO_CTRL_CNT_EN
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      tx_bytes <= '0;
      rx_bytes <= '0;
    end else begin
      if (state == TXWR)  tx_bytes <= tx_bytes + 16'd1;
      if (state == RXCAP) rx_bytes <= rx_bytes + 16'd1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_sio_fifo_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// Directed bench for sio_fifo_ctrl with a small serial-port slave model.
module tb_sio_fifo_ctrl;

  logic       clk = 1'b0;
  logic       n_rst, en, tx_wr, rx_rd;
  logic [7:0] tx_data;
  logic       tx_full, tx_drop, rx_empty;
  logic [7:0] rx_data;
  logic       sio_ce, sio_rd, sio_wr, sio_cd;
  logic [7:0] sio_wdata, sio_rdata;

  logic       en4, tx_wr4, rx_rd4;
  logic [7:0] tx_data4, sio_rdata4;
  logic       tx_full4, tx_drop4, rx_empty4;
  logic [7:0] rx_data4, sio_wdata4;
  logic       sio_ce4, sio_rd4, sio_wr4, sio_cd4;

`ifdef SIO_CTRL_CNT_EN
  logic [15:0] tx_bytes, rx_bytes, tx_bytes4, rx_bytes4;
`endif

  sio_fifo_ctrl #(.DEPTH_LOG2(3), .POLL_GAP(0)) dut (
`ifdef SIO_CTRL_CNT_EN
    .tx_bytes(tx_bytes), .rx_bytes(rx_bytes),
`endif
    .clk(clk), .n_rst(n_rst), .en(en), .tx_wr(tx_wr), .tx_data(tx_data),
    .tx_full(tx_full), .tx_drop(tx_drop), .rx_rd(rx_rd), .rx_data(rx_data),
    .rx_empty(rx_empty), .sio_ce(sio_ce), .sio_rd(sio_rd), .sio_wr(sio_wr),
    .sio_cd(sio_cd), .sio_wdata(sio_wdata), .sio_rdata(sio_rdata)
  );

  sio_fifo_ctrl #(.DEPTH_LOG2(3), .POLL_GAP(4)) dut4 (
`ifdef SIO_CTRL_CNT_EN
    .tx_bytes(tx_bytes4), .rx_bytes(rx_bytes4),
`endif
    .clk(clk), .n_rst(n_rst), .en(en4), .tx_wr(tx_wr4), .tx_data(tx_data4),
    .tx_full(tx_full4), .tx_drop(tx_drop4), .rx_rd(rx_rd4), .rx_data(rx_data4),
    .rx_empty(rx_empty4), .sio_ce(sio_ce4), .sio_rd(sio_rd4), .sio_wr(sio_wr4),
    .sio_cd(sio_cd4), .sio_wdata(sio_wdata4), .sio_rdata(sio_rdata4)
  );

  initial forever #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Serial-port slave: status reflects pending RX bytes and tx_ready.
  logic [7:0] rxq[$];
  logic       tx_ready = 1'b0;

  initial begin
    logic [7:0] nxt;
    sio_rdata = 8'h00;
    forever begin
      @(negedge clk);
      nxt = 8'h00;
      if (sio_ce && sio_rd && sio_cd)
        nxt = {6'b0, rxq.size() != 0, tx_ready};
      else if (sio_ce && sio_rd && !sio_cd && rxq.size() != 0)
        nxt = rxq.pop_front();
      @(posedge clk);
      #1 sio_rdata = nxt;
    end
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Bus monitor for both instances.
  logic [7:0] svc[$];
  logic [7:0] wq[$];
  int p4[$];
  int wr_cnt = 0, rd_cnt = 0, both_cnt = 0, idle_bad = 0, last_poll = 0, wr_gap = -1, ce4_cnt = 0;

  initial forever begin
    @(negedge clk);
    if (sio_ce && sio_rd && sio_cd) last_poll = cyc;
    if (sio_ce && sio_rd && !sio_cd) begin
      svc.push_back("R");
      rd_cnt++;
    end
    if (sio_ce && sio_wr) begin
      svc.push_back("T");
      wq.push_back(sio_wdata);
      wr_cnt++;
      wr_gap = cyc - last_poll;
    end
    if (sio_rd && sio_wr) both_cnt++;
    if (!sio_ce && (sio_rd || sio_wr || sio_cd || sio_wdata != 8'h00)) idle_bad++;
    if (sio_ce4) ce4_cnt++;
    if (sio_ce4 && sio_rd4 && sio_cd4) p4.push_back(cyc);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    n_rst = 1'b0;
    en = 1'b0;
    en4 = 1'b0;
    tx_ready = 1'b0;
    rxq.delete();
    repeat (2) tick();
    n_rst = 1'b1;
  endtask

  task automatic push_tx(input logic [7:0] b);
    tx_wr = 1'b1;
    tx_data = b;
    tick();
    tx_wr = 1'b0;
  endtask

  function automatic logic [7:0] qget(input int i);
    return (wq.size() > i) ? wq[i] : 8'hxx;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic got;
    n_rst = 1'b0; en = 1'b0; tx_wr = 1'b0; rx_rd = 1'b0; tx_data = 8'h00;
    en4 = 1'b0; tx_wr4 = 1'b0; rx_rd4 = 1'b0; tx_data4 = 8'h00; sio_rdata4 = 8'h00;
    repeat (3) tick();
    @(negedge clk);
    check("rst_strobes", {28'd0, sio_ce, sio_rd, sio_wr, sio_cd}, 32'h0);
    check("rst_wdata", {24'd0, sio_wdata}, 32'h0);
    check("rst_flags", {29'd0, tx_full, tx_drop, rx_empty}, 32'h1);
    do_reset();

    // TX: one byte, single write pulse, POLL->PCAP->TXWR spacing.
    tx_ready = 1'b1;
    wr_cnt = 0; rd_cnt = 0; wq.delete();
    push_tx(8'hA5);
    en = 1'b1;
    repeat (20) tick();
    en = 1'b0;
    repeat (5) tick();
    check("tx_wr_cnt", wr_cnt, 1);
    check("tx_wdata", {24'd0, qget(0)}, 32'hA5);
    check("tx_latency", wr_gap, 2);
    check("tx_no_rd", rd_cnt, 0);

    // RX: one byte from the port into the RX FIFO, then popped.
    tx_ready = 1'b0;
    rxq.push_back(8'h3C);
    en = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 30 && !got; i++) begin
      tick();
      got = !rx_empty;
    end
    en = 1'b0;
    check("rx_arrived", {31'd0, got}, 1);
    @(negedge clk);
    check("rx_data", {24'd0, rx_data}, 32'h3C);
    rx_rd = 1'b1;
    tick();
    rx_rd = 1'b0;
    @(negedge clk);
    check("rx_empty_after_rd", {31'd0, rx_empty}, 1);
    rx_rd = 1'b1;
    tick();
    rx_rd = 1'b0;
    @(negedge clk);
    check("rx_rd_on_empty", {31'd0, rx_empty}, 1);
    repeat (5) tick();

    // Tie: RX first after reset, then alternate.
    do_reset();
    push_tx(8'h11);
    push_tx(8'h22);
    rxq.push_back(8'h41); rxq.push_back(8'h42); rxq.push_back(8'h43);
    tx_ready = 1'b1;
    svc.delete(); wq.delete();
    en = 1'b1;
    for (int i = 0; i < 80 && svc.size() < 5; i++) tick();
    en = 1'b0;
    repeat (6) tick();
    check("tie_cnt", {31'd0, svc.size() >= 4}, 1);
    check("tie0", {24'd0, (svc.size() > 0) ? svc[0] : 8'h00}, 32'h52);
    check("tie1", {24'd0, (svc.size() > 1) ? svc[1] : 8'h00}, 32'h54);
    check("tie2", {24'd0, (svc.size() > 2) ? svc[2] : 8'h00}, 32'h52);
    check("tie3", {24'd0, (svc.size() > 3) ? svc[3] : 8'h00}, 32'h54);
    check("tie_tx_order", {16'd0, qget(0), qget(1)}, 32'h1122);
    @(negedge clk);
    check("tie_rx_head", {24'd0, rx_data}, 32'h41);

    // TX full: 8 accepted, the 9th dropped with a single tx_drop pulse.
    do_reset();
    for (int i = 0; i < 9; i++) begin
      tx_wr = 1'b1;
      tx_data = 8'h80 + 8'(i);
      @(negedge clk);
      check($sformatf("txf_drop%0d", i), {31'd0, tx_drop}, (i == 8) ? 1 : 0);
      if (i >= 7) check($sformatf("txf_full%0d", i), {31'd0, tx_full}, (i == 8) ? 1 : 0);
      tick();
    end
    tx_wr = 1'b0;
    @(negedge clk);
    check("txf_drop_end", {31'd0, tx_drop}, 0);
    wq.delete(); wr_cnt = 0;
    tx_ready = 1'b1;
    en = 1'b1;
    repeat (60) tick();
    en = 1'b0;
    repeat (5) tick();
    check("txf_drain_cnt", wr_cnt, 8);
    check("txf_drain_ends", {16'd0, qget(0), qget(7)}, 32'h8087);
    check("txf_not_full", {31'd0, tx_full}, 0);

    // RX full: stops reading once 8 bytes are held.
    do_reset();
    for (int i = 0; i < 10; i++) rxq.push_back(8'h50 + 8'(i));
    rd_cnt = 0;
    en = 1'b1;
    repeat (80) tick();
    en = 1'b0;
    repeat (5) tick();
    check("rxf_rd_cnt", rd_cnt, 8);
    check("rxf_left", rxq.size(), 2);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check($sformatf("rxf_data%0d", i), {24'd0, rx_data}, 32'h50 + i);
      rx_rd = 1'b1;
      tick();
      rx_rd = 1'b0;
    end
    @(negedge clk);
    check("rxf_empty", {31'd0, rx_empty}, 1);

    // Reset in the middle of TXWR.
    do_reset();
    tx_ready = 1'b1;
    push_tx(8'h77);
    en = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = sio_wr;
    end
    check("mid_found_txwr", {31'd0, got}, 1);
    n_rst = 1'b0;
    tick();
    @(negedge clk);
    check("mid_rst_strobes", {28'd0, sio_ce, sio_rd, sio_wr, sio_cd}, 32'h0);
    check("mid_rst_flags", {30'd0, tx_full, rx_empty}, 32'h1);
    tick();
    n_rst = 1'b1;
    wr_cnt = 0;
    repeat (20) tick();
    en = 1'b0;
    check("mid_fifo_flushed", wr_cnt, 0);

    // Poll spacing on the POLL_GAP=4 instance.
    repeat (5) tick();
    p4.delete();
    en4 = 1'b1;
    repeat (40) tick();
    en4 = 1'b0;
    check("gap_polls", {31'd0, p4.size() >= 4}, 1);
    for (int k = 1; k < 4; k++)
      check($sformatf("gap_spacing%0d", k), (p4.size() > k) ? (p4[k] - p4[k-1]) : -1, 6);
    repeat (5) tick();
    ce4_cnt = 0;
    repeat (30) tick();
    check("gap_en_low", ce4_cnt, 0);

    check("never_rd_and_wr", both_cnt, 0);
    check("idle_strobes_low", idle_bad, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sio_fifo_ctrl.md
SIO_FIFO_CTRL -- requirements
Module: sio_fifo_ctrl

Interface
REQ-001 SHALL have parameter DEPTH_LOG2, default 3: log2 of each FIFO depth (8 entries).
REQ-002 SHALL have parameter POLL_GAP, default 4: idle cycles between status polls (0 allowed).
REQ-003 SHALL have port clk, input, 1: single clock for all logic.
REQ-004 SHALL have port n_rst, input, 1: reset, synchronous and active-low.
REQ-005 SHALL have port en, input, 1: when high, the FSM may start new transactions.
REQ-006 SHALL have port tx_wr, input, 1: host pushes tx_data into the TX FIFO.
REQ-007 SHALL have port tx_data, input, 8: host TX byte.
REQ-008 SHALL have port tx_full, output, 1: TX FIFO full.
REQ-009 SHALL have port tx_drop, output, 1: one-cycle pulse when tx_wr is rejected.
REQ-010 SHALL have port rx_rd, input, 1: host pops the RX FIFO head.
REQ-011 SHALL have port rx_data, output, 8: RX FIFO head (show-ahead); valid while rx_empty=0.
REQ-012 SHALL have port rx_empty, output, 1: RX FIFO empty.
REQ-013 SHALL have ports sio_ce, sio_rd, sio_wr and sio_cd, outputs, 1 each: serial-port bus strobes; cd=1 selects status, cd=0 selects data.
REQ-014 SHALL have port sio_wdata, output, 8: byte written to the serial port.
REQ-015 SHALL have port sio_rdata, input, 8: serial-port read bus, registered one cycle after the read strobe; status bit1 = rx_ready, bit0 = tx_ready.

Function
REQ-016 SHALL implement FSM states IDLE, POLL, PCAP, RXRD, RXCAP and TXWR, with all strobes registered.
- IDLE: counts POLL_GAP cycles, then moves to POLL if en=1; otherwise it stays in IDLE with the counter held at 0.
REQ-017 SHALL, in POLL, drive ce=1, rd=1, cd=1 for one cycle, then move to PCAP.
REQ-018 SHALL, in PCAP, sample sio_rdata and decide:
- rx_ready=1 and RX FIFO not full goes to RXRD.
- tx_ready=1 and TX FIFO not empty goes to TXWR.
- Otherwise the FSM returns to IDLE.
REQ-019 SHALL arbitrate round-robin when both RX and TX are eligible: serve the opposite of last_served, which resets to TX, so RX wins the first tie.
REQ-020 SHALL, in RXRD, drive ce=1, rd=1, cd=0 for one cycle; in RXCAP, push sio_rdata into the RX FIFO; then go to IDLE.
REQ-021 SHALL, in TXWR, drive ce=1, wr=1, cd=0, with sio_wdata equal to the TX FIFO head, for one cycle, pop the TX FIFO, then go to IDLE.
REQ-022 SHALL never assert sio_rd and sio_wr together, and SHALL hold all strobes at 0 and sio_wdata at 8'h00 outside POLL, RXRD and TXWR.
REQ-023 SHALL finish a transaction in progress when en falls mid-transaction.
REQ-024 SHALL ignore tx_wr when tx_full=1 and pulse tx_drop; rx_rd while rx_empty=1 SHALL be ignored.
REQ-025 SHALL make FIFO pointers DEPTH_LOG2+1 bits wide and wrap modulo 2*depth.
- full: pointer MSBs differ and the LSBs are equal.
- A simultaneous push and pop on the same FIFO SHALL both take effect, leaving the count unchanged.
- A push to a full FIFO SHALL be accepted only if a pop occurs in the same cycle.
REQ-026 SHALL give a minimum TX latency, with POLL_GAP=0 and an idle link, of 3 cycles from tx_wr to sio_wr (POLL, PCAP, TXWR).

Reset
REQ-027 SHALL, while n_rst=0 at a clk edge, reset as follows.
- FSM to IDLE, gap counter 0, both FIFOs empty, last_served=TX.
- Outputs: sio_ce/rd/wr/cd=0, sio_wdata=8'h00, tx_full=0, tx_drop=0, rx_empty=1.
REQ-028 SHALL discard any transaction and any FIFO contents on a reset mid-operation; no strobe SHALL be asserted in the cycle after reset is sampled.

Configuration
REQ-029 SHALL, when macro SIO_CTRL_CNT_EN is defined, add two outputs.
- tx_bytes[15:0]: increments on each TXWR.
- rx_bytes[15:0]: increments on each RXCAP.
- Both wrap from 16'hFFFF to 0 and reset to 0.
REQ-030 SHALL, when SIO_CTRL_CNT_EN is undefined, omit those ports and counters entirely, with behaviour otherwise identical.

Verification
REQ-031 SHALL cover the following directed scenarios (POLL_GAP=0 unless noted).
- Reset: n_rst=0 for 2 cycles mid-TXWR -> next cycle all strobes 0, rx_empty=1, tx_full=0.
- TX: status 8'h01, tx_wr 8'hA5 -> POLL, PCAP, then TXWR with sio_wdata=8'hA5, exactly one wr pulse.
- RX: status 8'h02, then sio_rdata=8'h3C after RXRD -> rx_empty=0, rx_data=8'h3C; rx_rd -> rx_empty=1.
- Tie: status 8'h03 repeatedly, TX FIFO holding 2 bytes -> service order RX, TX, RX, TX.
- Full: 9 tx_wr with status 8'h00 -> tx_full after 8, tx_drop pulses once; 8 RX bytes with no rx_rd -> the controller stops issuing RXRD.
- Gap: POLL_GAP=4, en=1 -> POLL strobes exactly every 6 cycles while idle; en=0 -> no strobes.
